// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the cycles-per-bit rounding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } uart_state_t;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int clk_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, one stop bit, idle-high line.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
// A single baud counter is shared by every state; tx comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       newData
);

  localparam int CPB = clk_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          block_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic bit_done;
  logic accept;

  assign bit_done = (cnt == CNT_LAST);
  assign accept   = !block_q && newData;
  assign busy     = (state != IDLE) || block_q;

  // Frame sequencer: start, 8 data bits, [parity], stop, each CPB cycles long.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      block_q <= 1'b0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      block_q <= block;
      case (state)
        IDLE: begin
          cnt <= '0;
          tx  <= 1'b1;
          if (accept) begin
            shreg <= data;
`ifdef UART_TX_PARITY_EN
            par_q <= ^data;
`endif
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_q;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            // A byte offered on the edge that would enter IDLE starts the next
            // frame immediately, so back-to-back frames have no idle gap.
            if (accept) begin
              shreg <= data;
`ifdef UART_TX_PARITY_EN
              par_q <= ^data;
`endif
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with randomized bytes, dropped requests and
// mid-frame block pulses, checked against a bit-list model of the frame.
module tb_uart_tx;

  localparam int CLK_FREQ = 100000000;
  localparam int BAUD     = 1000000;
  localparam int CPB      = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN = NB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       block;
  logic       busy;
  logic [7:0] data;
  logic       newData;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .tx(tx), .block(block),
    .busy(busy), .data(data), .newData(newData)
  );

  always #5 clk = ~clk;

  // Line bits of one frame in transmit order: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    b[9] = ^d;
`endif
    return b;
  endfunction

  // Called at the negedge of the first frame cycle; leaves at the negedge
  // just after the frame. Optionally injects a dropped request and a block pulse.
  task automatic check_frame(input string name, input logic [7:0] d,
                             input int drop_at, input logic [7:0] drop_d,
                             input int blk_at, input int blk_len);
    logic [10:0] b;
    int bad, first;
    logic ftx, fbusy;
    b = frame_bits(d);
    bad = 0; first = -1; ftx = 1'b0; fbusy = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      if (tx !== b[k / CPB] || busy !== 1'b1) begin
        if (first < 0) begin first = k; ftx = tx; fbusy = busy; end
        bad++;
      end
      if (k == drop_at) begin newData = 1'b1; data = drop_d; end
      else if (k == drop_at + 1) newData = 1'b0;
      if (k == blk_at) block = 1'b1;
      else if (k == blk_at + blk_len) block = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s byte=%02h: %0d bad cycles, first at %0d got tx=%b busy=%b, expected tx=%b busy=1",
               name, d, bad, first, ftx, fbusy, b[first / CPB]);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s: %0d of %0d cycles not idle, expected tx=1 busy=0", name, bad, n);
    end
  endtask

  task automatic send(input logic [7:0] d);
    newData = 1'b1; data = d;
    @(negedge clk);
    newData = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; block = 1'b0; newData = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_frame_and_drop;
    send(8'h55);
    check_frame("frame_55_drop_a3", 8'h55, 300, 8'hA3, -10, 0);
    check_idle("idle_after_drop", 50);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      int da, ba, bl;
      d  = 8'($urandom);
      da = $urandom_range(FLEN - 3, 0);
      ba = $urandom_range(FLEN - 20, 0);
      bl = $urandom_range(10, 1);
      send(d);
      check_frame("random_frame", d, da, 8'($urandom), ba, bl);
      check_idle("random_idle", 3);
    end
  endtask

  task automatic test_block;
    block = 1'b1;
    @(negedge clk);
    send(8'h0F);
    n_cmp++;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 300; k++) begin
        if (tx !== 1'b1 || busy !== 1'b1) bad++;
        @(negedge clk);
      end
      if (bad !== 0) begin
        n_bad++;
        $display("FAIL block_hold: %0d cycles wrong, expected tx=1 busy=1", bad);
      end
    end
    block = 1'b0;
    @(negedge clk);
    check_idle("block_release", 20);
  endtask

  task automatic test_reset_mid;
    logic [10:0] b;
    int bad;
    b = frame_bits(8'hFF);
    bad = 0;
    send(8'hFF);
    for (int k = 0; k < 350; k++) begin
      if (tx !== b[k / CPB] || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL partial_ff: %0d bad cycles before reset", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset_mid", 2 * CPB);
    send(8'h01);
    check_frame("frame_01_after_reset", 8'h01, -10, 8'h00, -10, 0);
    check_idle("idle_after_01", 5);
  endtask

  task automatic test_back_to_back;
    send(8'h00);
    newData = 1'b1; data = 8'hFF;
    check_frame("b2b_first", 8'h00, -10, 8'h00, -10, 0);
    newData = 1'b0;
    check_frame("b2b_second", 8'hFF, -10, 8'h00, -10, 0);
    check_idle("idle_after_b2b", 5);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    send(8'h07);
    check_frame("parity_07", 8'h07, -10, 8'h00, -10, 0);
    check_idle("idle_after_07", 3);
    send(8'h03);
    check_frame("parity_03", 8'h03, -10, 8'h00, -10, 0);
    check_idle("idle_after_03", 3);
  endtask
`endif

  initial begin
    rst = 1'b1; block = 1'b0; newData = 1'b0; data = 8'h00;
    @(negedge clk);
    test_reset();
    test_frame_and_drop();
    test_random();
    test_block();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100000000, meaning the clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 1000000, meaning the serial bit rate in bit/s.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-006 The module SHALL have port block, input, 1 bit: when high, no new byte is accepted (flow control from the downstream side).
REQ-007 The module SHALL have port busy, output, 1 bit: when high, newData is ignored.
REQ-008 The module SHALL have port data, input, 8 bits: the byte to send, sampled when accepted.
REQ-009 The module SHALL have port newData, input, 1 bit: single-cycle request to send data.

Function
REQ-010 CLK_PER_BIT SHALL be (CLK_FREQ + BAUD/2) / BAUD, integer-rounded; the bit counter width SHALL be clog2(CLK_PER_BIT).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when the REQ-020 macro is defined.
REQ-012 A byte SHALL be accepted on an edge where state==IDLE, the registered block is low and newData is high; data SHALL be latched on that edge.
REQ-013 tx SHALL go low on the cycle after acceptance and stay low for exactly CLK_PER_BIT cycles (START).
REQ-014 In DATA, the 8 bits SHALL be driven LSB first, each for exactly CLK_PER_BIT cycles.
REQ-015 In STOP, tx SHALL be high for exactly CLK_PER_BIT cycles, after which the FSM SHALL return to IDLE.
REQ-016 A frame SHALL take 10*CLK_PER_BIT cycles without parity and 11*CLK_PER_BIT cycles with parity.
REQ-017 busy SHALL be high when state!=IDLE or the registered block is high; block SHALL be registered with one-cycle latency.
REQ-018 newData while busy SHALL be dropped, with no queuing and no effect on the frame in flight.
REQ-019 Asserting block mid-frame SHALL NOT abort the frame; it SHALL only prevent the next acceptance.
REQ-019a A byte offered on the cycle the FSM enters IDLE SHALL be accepted, giving back-to-back frames with no idle gap.

Configuration
REQ-020 When UART_TX_PARITY_EN is defined, a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles.
REQ-021 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Reset
REQ-022 While rst is high, tx SHALL be 1, state SHALL be IDLE, and the bit counter, bit index and registered block SHALL be 0.
REQ-023 busy SHALL be 0 on the first cycle after rst deasserts, unless block was high during that cycle.
REQ-024 Reset mid-frame SHALL abort the frame and drive tx high on the next edge; the partial byte SHALL NOT be resent.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state encoding and the CLK_PER_BIT rounding function, for reuse by uart_rx.
REQ-026 The design SHALL have no sub-module; the baud counter SHALL be inline, because a single counter shared across states is simplest.
REQ-027 tx SHALL be driven from a flop, with no combinational path from inputs to tx.

Verification
REQ-028 With the defaults (100 cycles/bit), a newData pulse with data=0x55 SHALL produce tx low 100 cycles, then the pattern 1,0,1,0,1,0,1,0 at 100 cycles each, then high 100 cycles; busy SHALL be high for 1000 cycles starting the cycle after acceptance.
REQ-029 A newData pulse with data=0xA3 during the 0x55 frame SHALL be dropped, and the line SHALL carry only the 0x55 frame.
REQ-030 With block held high and a newData pulse with data=0x0F, there SHALL be no frame; tx SHALL stay 1 and busy SHALL stay 1.
REQ-031 A frame for 0xFF with rst asserted at cycle 350 SHALL give tx=1 and busy=0 on the following cycles; a new newData with data=0x01 SHALL then produce a clean full frame.
REQ-032 Holding newData high and busy-gating data=0x00 then 0xFF SHALL produce back-to-back frames with a stop-to-start gap of 0 cycles.
REQ-033 With UART_TX_PARITY_EN defined, data=0x07 SHALL produce a parity bit of 1 and a frame of 1100 cycles; data=0x03 SHALL produce a parity bit of 0.
